// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared commands, FSM states and sizing helper for the PCI target buffer
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        TURN_AR,
        DATA,
        BACKOFF,
        TURN
    } pciState_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/pci_target_burst_buffer_if.sv
// rtl/pci_target_burst_buffer_if.sv - PCI target bus bundle with master/slave views
interface pci_target_burst_buffer_if #(
    parameter int DATA_W = 32
);
    logic                  frame_n;
    logic [DATA_W/8-1:0]   cbe_n;
    logic                  irdy_n;
    logic                  trdy_n;
    logic                  devsel_n;
    logic                  stop_n;

    // Each side drives AD only under its own enable; the shared net resolves here.
    logic [DATA_W-1:0]     adOut;
    logic                  adOe;
    logic [DATA_W-1:0]     mstAd;
    logic                  mstAdOe;
    wire  [DATA_W-1:0]     ad;

    assign ad = adOe ? adOut : (mstAdOe ? mstAd : {DATA_W{1'bz}});

    modport slave (
        input  frame_n, cbe_n, irdy_n, ad,
        output trdy_n, devsel_n, stop_n, adOut, adOe
    );

    modport master (
        input  trdy_n, devsel_n, stop_n, ad, adOe,
        output frame_n, cbe_n, irdy_n, mstAd, mstAdOe
    );

endinterface

// File: rtl/pci_target_mem.sv
// rtl/pci_target_mem.sv - word store with per-byte write enables and asynchronous read
module pci_target_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic                 clk,
    input  logic [PTR_W-1:0]     wrAddr,
    input  logic [DATA_W-1:0]    wrData,
    input  logic [DATA_W/8-1:0]  wrBe,
    input  logic [PTR_W-1:0]     rdAddr,
    output logic [DATA_W-1:0]    rdData
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (wrBe[i]) begin
                mem[wrAddr][i*8 +: 8] <= wrData[i*8 +: 8];
            end
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/pci_target_burst_buffer.sv
// rtl/pci_target_burst_buffer.sv - PCI memory target: decode, linear bursts, wait states, disconnect
module pci_target_burst_buffer
    import pci_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    pci_target_burst_buffer_if.slave  bus
);
    localparam int BYTES     = DATA_W / 8;
    localparam int PTR_W     = clog2(DEPTH);
    localparam int OFF_W     = clog2(BYTES);
    localparam int WIN_BYTES = DEPTH * BYTES;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    pciState_t         state, stateNext;
    logic [PTR_W-1:0]  ptr, ptrNext;
    logic [2:0]        waitCnt, waitCntNext;
    logic              isRead, isReadNext;
    logic              ignoreBus, ignoreBusNext;
    logic [DATA_W-1:0] rdWord, memRdData;
    logic [BYTES-1:0]  wrBe;

    logic [31:0]       addr;
    logic [3:0]        cmd;
    logic              inWindow, addrHit, xfer;
    logic [PTR_W-1:0]  startPtr;

    assign addr     = bus.ad[31:0];
    assign cmd      = bus.cbe_n[3:0];
    assign inWindow = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, addr} <  ({1'b0, BASE_ADDR} + 33'(WIN_BYTES)));
    assign addrHit  = inWindow && (cmd == CMD_MEM_READ || cmd == CMD_MEM_WRITE);
    assign startPtr = PTR_W'((addr - BASE_ADDR) >> OFF_W);
    assign xfer     = (state == DATA) && !bus.irdy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            waitCnt   <= '0;
            isRead    <= 1'b0;
            ignoreBus <= 1'b0;
            rdWord    <= '0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            waitCnt   <= waitCntNext;
            isRead    <= isReadNext;
            ignoreBus <= ignoreBusNext;
            // Read port follows the next pointer so the word is registered when DATA begins.
            rdWord    <= memRdData;
        end
    end

    always_comb begin
        stateNext     = state;
        ptrNext       = ptr;
        waitCntNext   = waitCnt;
        isReadNext    = isRead;
        ignoreBusNext = ignoreBus;
        wrBe          = '0;

        case (state)
            IDLE: begin
                if (ignoreBus) begin
                    if (bus.frame_n && bus.irdy_n) begin
                        ignoreBusNext = 1'b0;
                    end
                end else if (!bus.frame_n) begin
                    if (addrHit) begin
                        isReadNext  = (cmd == CMD_MEM_READ);
                        ptrNext     = startPtr;
                        waitCntNext = 3'(WAIT_STATES - 1);
                        if (cmd == CMD_MEM_READ) begin
                            stateNext = TURN_AR;
                        end else begin
                            stateNext = (WAIT_STATES == 0) ? DATA : WAIT;
                        end
                    end else begin
                        ignoreBusNext = 1'b1;
                    end
                end
            end
            TURN_AR: begin
                stateNext = (WAIT_STATES == 0) ? DATA : WAIT;
            end
            WAIT: begin
                if (waitCnt == 3'd0) begin
                    stateNext = DATA;
                end else begin
                    waitCntNext = waitCnt - 3'd1;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (!isRead) begin
                        wrBe = ~bus.cbe_n;
                    end
                    if (bus.frame_n) begin
                        stateNext = TURN;
                    end else if (ptr == LAST_PTR) begin
                        stateNext = BACKOFF;
                    end else begin
                        ptrNext = ptr + 1'b1;
                    end
                end
            end
            BACKOFF: begin
                if (bus.frame_n) begin
                    stateNext = TURN;
                end
            end
            TURN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.devsel_n = !(state inside {WAIT, TURN_AR, DATA, BACKOFF});
        bus.trdy_n   = (state != DATA);
        bus.stop_n   = !((state == BACKOFF) || (state == DATA && ptr == LAST_PTR));
        bus.adOe     = (state == DATA) && isRead;
        bus.adOut    = rdWord;
    end

    pci_target_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wrAddr (ptr),
        .wrData (bus.ad),
        .wrBe   (rst ? '0 : wrBe),
        .rdAddr (ptrNext),
        .rdData (memRdData)
    );

endmodule

// File: tb/tb_pci_target_burst_buffer.sv
// tb/tb_pci_target_burst_buffer.sv - vector-table bench for two PCI target windows on one master
module tb_pci_target_burst_buffer;
    import pci_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        int          nWords;
        logic [3:0]  be;
        logic [31:0] data [5];
        int          stallAt;
        int          stallLen;
        int          hold;
        int          expLat;
        int          expXfers;
        int          expStopAt;
        logic        expHit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frameN, irdyN, mstAdOe;
    logic [3:0]  cbeN;
    logic [31:0] mstAd;

    int tests = 0;
    int failures = 0;

    vec_t        vecs [14];
    logic [31:0] model [2][DEPTH];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    pci_target_burst_buffer_if #(.DATA_W(32)) bus0 ();
    pci_target_burst_buffer_if #(.DATA_W(32)) bus1 ();

    assign bus0.frame_n = frameN;
    assign bus0.cbe_n   = cbeN;
    assign bus0.irdy_n  = irdyN;
    assign bus0.mstAd   = mstAd;
    assign bus0.mstAdOe = mstAdOe;
    assign bus1.frame_n = frameN;
    assign bus1.cbe_n   = cbeN;
    assign bus1.irdy_n  = irdyN;
    assign bus1.mstAd   = mstAd;
    assign bus1.mstAdOe = mstAdOe;

    pci_target_burst_buffer #(
        .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    pci_target_burst_buffer #(
        .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(2)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        trdyObs, devselObs, stopObs, adOeObs;
    logic [31:0] adObs;
    assign trdyObs   = bus0.trdy_n & bus1.trdy_n;
    assign devselObs = bus0.devsel_n & bus1.devsel_n;
    assign stopObs   = bus0.stop_n & bus1.stop_n;
    assign adOeObs   = bus0.adOe | bus1.adOe;
    assign adObs     = bus0.adOe ? bus0.ad : bus1.ad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", tag, idx, act, exp);
        end
    endtask

    task automatic checkQuiet(input string tag, input int idx);
        chk(tag, idx, {28'd0, trdyObs, devselObs, stopObs, adOeObs}, 32'hE);
    endtask

    task automatic checkBackoff(input int idx);
        chk("backoff outputs", idx, {28'd0, trdyObs, devselObs, stopObs, adOeObs}, 32'h8);
    endtask

    task automatic runBurst(input int idx);
        vec_t        v;
        int          inst, start, w, cyc, phase, stallCnt, xfers, lat, stopAt;
        logic        isRd, stalling, devselSeen, stopped;
        logic        t, d, s, oe;
        logic [31:0] a, exp;
        v     = vecs[idx];
        isRd  = (v.cmd == CMD_MEM_READ);
        inst  = (v.addr >= BASE1) ? 1 : 0;
        start = int'((v.addr - ((inst == 1) ? BASE1 : 32'h0)) >> 2);
        sb.delete();
        if (v.expHit) begin
            for (int i = 0; i < v.nWords; i++) begin
                w = start + i;
                if (w < DEPTH) begin
                    if (isRd) begin
                        sb.push_back(model[inst][w]);
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (!v.be[b]) model[inst][w][b*8 +: 8] = v.data[i][b*8 +: 8];
                        end
                    end
                end
            end
        end

        frameN = 1'b0; irdyN = 1'b1; cbeN = v.cmd; mstAd = v.addr; mstAdOe = 1'b1;
        tick();
        cyc = 1; phase = 0; stallCnt = 0; xfers = 0; lat = -1; stopAt = -1;
        devselSeen = 1'b0; stopped = 1'b0;
        while (phase < v.nWords && cyc < 16 && !stopped) begin
            t = trdyObs; d = devselObs; s = stopObs; oe = adOeObs; a = adObs;
            stalling = (phase == v.stallAt) && (stallCnt < v.stallLen);
            frameN  = (phase == v.nWords - 1) && !stalling;
            irdyN   = stalling;
            cbeN    = v.be;
            mstAdOe = !isRd;
            mstAd   = v.data[phase];
            if (!d) devselSeen = 1'b1;
            if (!t && lat < 0) lat = cyc;
            if (t) chk("ad released while trdy high", idx, 32'(oe), 32'd0);
            if (stalling) begin
                stallCnt++;
                if (isRd && !t && sb.size() > 0) chk("ad held during stall", idx, a, sb[0]);
            end
            if (!irdyN && !t) begin
                if (!s && stopAt < 0) stopAt = phase;
                if (isRd) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                    chk("read ad enable", idx, 32'(oe), 32'd1);
                    chk("read data", idx, a, exp);
                end
                stopped = !s && !frameN;
                xfers++;
                phase++;
            end
            tick();
            cyc++;
        end

        if (stopped) begin
            for (int h = 0; h < v.hold; h++) begin
                checkBackoff(idx);
                frameN = 1'b0; irdyN = 1'b0;
                tick();
            end
            checkBackoff(idx);
            frameN = 1'b1;
            tick();
            checkQuiet("turn after backoff", idx);
        end else if (phase == v.nWords) begin
            checkQuiet("turn", idx);
        end
        frameN = 1'b1; irdyN = 1'b1; mstAdOe = 1'b0;
        tick();
        checkQuiet("idle", idx);

        chk("first trdy latency", idx, lat, v.expLat);
        chk("transfer count", idx, xfers, v.expXfers);
        chk("stop phase", idx, stopAt, v.expStopAt);
        chk("devsel asserted", idx, 32'(devselSeen), 32'(v.expHit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0]  = '{CMD_MEM_WRITE, 32'h0000_0000, 4, 4'b0000, '{32'd287, 32'd1000, 32'd133, 32'd176, 32'd0}, -1, 0, 0, 1, 4, -1, 1'b1};
        vecs[1]  = '{CMD_MEM_READ,  32'h0000_0000, 4, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 2, 4, -1, 1'b1};
        vecs[2]  = '{CMD_MEM_WRITE, 32'h0000_0100, 4, 4'b0000, '{32'd287, 32'd1000, 32'd133, 32'd176, 32'd0}, -1, 0, 0, 3, 4, -1, 1'b1};
        vecs[3]  = '{CMD_MEM_READ,  32'h0000_0100, 4, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1, 2, 0, 4, 4, -1, 1'b1};
        vecs[4]  = '{CMD_MEM_WRITE, 32'h0000_0010, 1, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 1, 1, -1, 1'b1};
        vecs[5]  = '{CMD_MEM_WRITE, 32'h0000_0010, 1, 4'b1100, '{32'hAABB_CCDD, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 1, 1, -1, 1'b1};
        vecs[6]  = '{CMD_MEM_READ,  32'h0000_0010, 1, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 2, 1, -1, 1'b1};
        vecs[7]  = '{CMD_MEM_WRITE, 32'h0000_0018, 5, 4'b0000, '{32'h0000_00A0, 32'h0000_00BB, 32'h0000_00CC, 32'h0000_00DD, 32'h0000_00EE}, -1, 0, 2, 1, 2, 1, 1'b1};
        vecs[8]  = '{CMD_MEM_READ,  32'h0000_0018, 2, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 2, 2, 1, 1'b1};
        vecs[9]  = '{CMD_MEM_READ,  32'h0000_0000, 1, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 2, 1, -1, 1'b1};
        vecs[10] = '{CMD_MEM_WRITE, 32'h0000_0020, 2, 4'b0110, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, -1, 0, -1, 1'b0};
        vecs[11] = '{4'b0010,       32'h0000_0000, 2, 4'b0110, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, -1, 0, -1, 1'b0};
        vecs[12] = '{CMD_MEM_WRITE, 32'h0000_0008, 1, 4'b0000, '{32'h1234_5678, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 1, 1, -1, 1'b1};
        vecs[13] = '{CMD_MEM_READ,  32'h0000_0008, 1, 4'b0000, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, -1, 0, 0, 2, 1, -1, 1'b1};
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < DEPTH; j++) model[k][j] = 32'd0;
        end

        rst = 1'b1; frameN = 1'b1; irdyN = 1'b1; cbeN = 4'hF; mstAd = 32'd0; mstAdOe = 1'b0;
        repeat (3) tick();
        checkQuiet("reset state", 99);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) runBurst(i);

        // Abort a read burst with reset while the target is in its data phase.
        frameN = 1'b0; irdyN = 1'b1; cbeN = CMD_MEM_READ; mstAd = 32'h0; mstAdOe = 1'b1;
        tick();
        frameN = 1'b0; irdyN = 1'b0; cbeN = 4'h0; mstAdOe = 1'b0;
        tick();
        chk("trdy before reset", 100, 32'(trdyObs), 32'd0);
        rst = 1'b1;
        tick();
        checkQuiet("outputs after mid-burst reset", 100);
        rst = 1'b0; frameN = 1'b1; irdyN = 1'b1;
        tick();
        checkQuiet("idle after reset release", 100);

        runBurst(12);
        runBurst(13);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
